ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-formation stage that drives the ALU's Operand1, Operand2 and AluContrl inputs.
- Captures decoded instruction fields from the decode stage on each clock.
- Applies MEM/WB result forwarding and source muxing, and flags load-use hazards to the hazard unit.
- Downstream consumers are the ALU and the EX/MEM register (store data, rd, control bits).

Parameters:
XLEN, 32, datapath width
CTRL_W, 4, width of ALU control code
BUBBLE_CTRL, 4'd3, ALU code loaded on reset/bubble (ADD)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
stall_e  in  1  hold E-stage register contents
flush_e  in  1  load a bubble into E stage
valid_d  in  1  decode slot holds a real instruction
pc_d  in  XLEN  instruction PC
rs1_d  in  5  source reg 1 index
rs2_d  in  5  source reg 2 index
rd_d  in  5  destination index
reg1_d  in  XLEN  register-file read data 1
reg2_d  in  XLEN  register-file read data 2
imm_d  in  XLEN  sign-extended immediate
alu_ctrl_d  in  CTRL_W  ALU operation code
alu_src1_d  in  1  0: rs1 value, 1: PC
alu_src2_d  in  2  00: rs2 value, 01: imm, 10: constant 4, 11: imm
reg_write_d  in  1  instruction writes rd
mem_read_d  in  1  instruction is a load
mem_write_d  in  1  instruction is a store
fwd_rd_m / fwd_we_m / fwd_data_m  in  5/1/XLEN  MEM-stage forward source
fwd_rd_w / fwd_we_w / fwd_data_w  in  5/1/XLEN  WB-stage forward source
operand1  out  XLEN  ALU Operand1
operand2  out  XLEN  ALU Operand2
alu_ctrl_e  out  CTRL_W  ALU AluContrl
store_data_e  out  XLEN  forwarded rs2 value for stores
pc_e  out  XLEN  registered PC
rd_e  out  5  registered rd
reg_write_e / mem_read_e / mem_write_e  out  1  registered control
valid_e  out  1  E slot valid
load_use_stall  out  1  load-use hazard request to hazard unit

Behaviour:
- The E register holds pc, rs1, rs2, rd, reg1, reg2, imm, alu_ctrl, alu_src1, alu_src2, reg_write, mem_read, mem_write and valid.
- rst (async, immediate, any time incl. mid-stall):
  - All E fields are 0, except alu_ctrl = BUBBLE_CTRL.
  - Resulting outputs: operand1 = operand2 = 0, alu_ctrl_e = 3, valid_e = 0, load_use_stall = 0.
- Each rising edge, priority flush_e > stall_e > load:
  - flush_e: bubble. valid, reg_write, mem_read, mem_write, rd, rs1 and rs2 are all 0; alu_ctrl = BUBBLE_CTRL; other fields are don't-care, driven 0.
  - stall_e (no flush): all fields hold.
  - Otherwise: capture all *_d inputs.
  - If valid_d = 0, the captured instruction has reg_write, mem_read and mem_write forced to 0.
- Latency: one cycle from D inputs to E outputs. Operand outputs are combinational from E registers plus the current forwarding inputs.
- Forwarding, per source (rs1_e → fv1, rs2_e → fv2):
  - MEM forwards if fwd_we_m = 1, fwd_rd_m != 0 and fwd_rd_m equals the source index.
  - Otherwise WB forwards under the same conditions using fwd_rd_w.
  - Otherwise the registered reg value is used.
  - MEM always beats WB. Index 0 is never forwarded.
- operand1 = alu_src1 ? pc_e : fv1.
- operand2 = fv2 / imm / 32'd4 per alu_src2; encoding 11 behaves as 01.
- store_data_e = fv2, regardless of alu_src2.
- All arithmetic is width XLEN, with no extension.
- load_use_stall (combinational) = valid_e & mem_read_e & (rd_e != 0) & valid_d & (rd_e == rs1_d | rd_e == rs2_d).
  - The hazard unit responds by stalling D and asserting flush_e. The bubble clears mem_read_e, so load_use_stall drops the next cycle.
- Simultaneous stall_e and flush_e: bubble.
- Outputs of a held (stalled) slot continue to re-evaluate forwarding every cycle.

Test Plan:
- Reset: assert rst mid-cycle with a valid instruction in E → outputs change immediately, without waiting for a clock edge: valid_e = 0, alu_ctrl_e = 3, operand1 = operand2 = 0, load_use_stall = 0, reg_write_e = 0.
- Capture: valid_d = 1, reg1_d = 0x10, imm_d = 0xFFFFFFF0, alu_src2_d = 01, alu_ctrl_d = 3 → after one edge: operand1 = 0x10, operand2 = 0xFFFFFFF0, alu_ctrl_e = 3.
- Forward priority: rs1_e = 5; M(rd 5, we 1, 0xAAAA) and W(rd 5, we 1, 0xBBBB) → operand1 = 0xAAAA. Set fwd_we_m = 0 → operand1 = 0xBBBB. With rs1_e = 0 and both forward sources set to rd 0 → operand1 = reg1 value.
- Stall/flush: stall_e = 1 for 3 edges with changing D inputs → all E outputs unchanged. Then stall_e = flush_e = 1 → valid_e = 0, reg_write_e = 0, alu_ctrl_e = 3.
- Load-use: E holds a load with rd_e = 7, D has rs2_d = 7, valid_d = 1 → load_use_stall = 1. Assert flush_e for one edge → load_use_stall = 0. With a load to rd_e = 0 → load_use_stall = 0.
- PC source: alu_src1_d = 1, alu_src2_d = 10, pc_d = 0x100, reg2_d = 0x55 with W forwarding rs2 as 0x77 → operand1 = 0x100, operand2 = 4, store_data_e = 0x77.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register plus operand formation (forwarding + source muxing) for the ALU.
// Latency: one cycle from decode inputs to E-stage register; operands are combinational from E + forwards.
// Backpressure: stall_e holds the slot, flush_e loads a bubble (wins over stall); load_use_stall asks for that.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   stall_e, flush_e         hold / bubble control from the hazard unit
//   *_d                      decoded instruction fields from the decode stage
//   fwd_{rd,we,data}_{m,w}   MEM and WB result forwarding sources
//   operand1/2, alu_ctrl_e   ALU inputs
//   store_data_e, pc_e, rd_e, reg_write_e, mem_read_e, mem_write_e, valid_e   to the EX/MEM register
//   load_use_stall           load-use hazard request to the hazard unit
module ex_operand_stage #(
    parameter int                XLEN        = 32,
    parameter int                CTRL_W      = 4,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = 4'd3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic              valid_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [4:0]        rs1_d,
    input  logic [4:0]        rs2_d,
    input  logic [4:0]        rd_d,
    input  logic [XLEN-1:0]   reg1_d,
    input  logic [XLEN-1:0]   reg2_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic [CTRL_W-1:0] alu_ctrl_d,
    input  logic              alu_src1_d,
    input  logic [1:0]        alu_src2_d,
    input  logic              reg_write_d,
    input  logic              mem_read_d,
    input  logic              mem_write_d,
    input  logic [4:0]        fwd_rd_m,
    input  logic              fwd_we_m,
    input  logic [XLEN-1:0]   fwd_data_m,
    input  logic [4:0]        fwd_rd_w,
    input  logic              fwd_we_w,
    input  logic [XLEN-1:0]   fwd_data_w,
    output logic [XLEN-1:0]   operand1,
    output logic [XLEN-1:0]   operand2,
    output logic [CTRL_W-1:0] alu_ctrl_e,
    output logic [XLEN-1:0]   store_data_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [4:0]        rd_e,
    output logic              reg_write_e,
    output logic              mem_read_e,
    output logic              mem_write_e,
    output logic              valid_e,
    output logic              load_use_stall
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   reg1;
        logic [XLEN-1:0]   reg2;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] alu_ctrl;
        logic              alu_src1;
        logic [1:0]        alu_src2;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } e_slot_t;

    // A bubble is an all-zero slot executing ADD, so the ALU sees 0 + 0.
    function automatic e_slot_t bubble_slot();
        e_slot_t s;
        s          = '0;
        s.alu_ctrl = BUBBLE_CTRL;
        return s;
    endfunction

    // MEM beats WB; x0 is hard-wired so it is never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      src,
        input logic [XLEN-1:0] regval,
        input logic [4:0]      rd_m,
        input logic            we_m,
        input logic [XLEN-1:0] dat_m,
        input logic [4:0]      rd_w,
        input logic            we_w,
        input logic [XLEN-1:0] dat_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == src)) begin
            return dat_m;
        end
        if (we_w && (rd_w != 5'd0) && (rd_w == src)) begin
            return dat_w;
        end
        return regval;
    endfunction

    e_slot_t       e_q;
    e_slot_t       d_slot;
    logic [XLEN-1:0] fv1;
    logic [XLEN-1:0] fv2;

    // An empty decode slot must not leave side effects in E, so its control bits are squashed.
    always_comb begin
        d_slot           = '0;
        d_slot.valid     = valid_d;
        d_slot.pc        = pc_d;
        d_slot.rs1       = rs1_d;
        d_slot.rs2       = rs2_d;
        d_slot.rd        = rd_d;
        d_slot.reg1      = reg1_d;
        d_slot.reg2      = reg2_d;
        d_slot.imm       = imm_d;
        d_slot.alu_ctrl  = alu_ctrl_d;
        d_slot.alu_src1  = alu_src1_d;
        d_slot.alu_src2  = alu_src2_d;
        d_slot.reg_write = reg_write_d & valid_d;
        d_slot.mem_read  = mem_read_d & valid_d;
        d_slot.mem_write = mem_write_d & valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= bubble_slot();
        end else if (flush_e) begin
            e_q <= bubble_slot();
        end else if (!stall_e) begin
            e_q <= d_slot;
        end
    end

    // Forwarding is evaluated from the live MEM/WB inputs, so a stalled slot keeps picking up
    // results that retire while it waits.
    assign fv1 = fwd_sel(e_q.rs1, e_q.reg1, fwd_rd_m, fwd_we_m, fwd_data_m,
                         fwd_rd_w, fwd_we_w, fwd_data_w);
    assign fv2 = fwd_sel(e_q.rs2, e_q.reg2, fwd_rd_m, fwd_we_m, fwd_data_m,
                         fwd_rd_w, fwd_we_w, fwd_data_w);

    assign operand1 = e_q.alu_src1 ? e_q.pc : fv1;

    // Encoding 11 is treated as immediate.
    always_comb begin
        operand2 = e_q.imm;
        case (e_q.alu_src2)
            2'b00:   operand2 = fv2;
            2'b10:   operand2 = XLEN'(4);
            default: operand2 = e_q.imm;
        endcase
    end

    assign store_data_e = fv2;
    assign alu_ctrl_e   = e_q.alu_ctrl;
    assign pc_e         = e_q.pc;
    assign rd_e         = e_q.rd;
    assign reg_write_e  = e_q.reg_write;
    assign mem_read_e   = e_q.mem_read;
    assign mem_write_e  = e_q.mem_write;
    assign valid_e      = e_q.valid;

    // A load in E cannot forward its data to the instruction right behind it in D.
    assign load_use_stall = e_q.valid & e_q.mem_read & (e_q.rd != 5'd0) & valid_d &
                            ((e_q.rd == rs1_d) | (e_q.rd == rs2_d));

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

    logic        clk;
    logic        rst;
    logic        stall_e, flush_e, valid_d;
    logic [31:0] pc_d, reg1_d, reg2_d, imm_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [3:0]  alu_ctrl_d;
    logic        alu_src1_d;
    logic [1:0]  alu_src2_d;
    logic        reg_write_d, mem_read_d, mem_write_d;
    logic [4:0]  fwd_rd_m, fwd_rd_w;
    logic        fwd_we_m, fwd_we_w;
    logic [31:0] fwd_data_m, fwd_data_w;
    logic [31:0] operand1, operand2, store_data_e, pc_e;
    logic [3:0]  alu_ctrl_e;
    logic [4:0]  rd_e;
    logic        reg_write_e, mem_read_e, mem_write_e, valid_e, load_use_stall;

    int checks = 0;
    int errors = 0;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .pc_d(pc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .reg1_d(reg1_d),
        .reg2_d(reg2_d), .imm_d(imm_d), .alu_ctrl_d(alu_ctrl_d), .alu_src1_d(alu_src1_d),
        .alu_src2_d(alu_src2_d), .reg_write_d(reg_write_d), .mem_read_d(mem_read_d),
        .mem_write_d(mem_write_d), .fwd_rd_m(fwd_rd_m), .fwd_we_m(fwd_we_m),
        .fwd_data_m(fwd_data_m), .fwd_rd_w(fwd_rd_w), .fwd_we_w(fwd_we_w),
        .fwd_data_w(fwd_data_w), .operand1(operand1), .operand2(operand2),
        .alu_ctrl_e(alu_ctrl_e), .store_data_e(store_data_e), .pc_e(pc_e), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
        .valid_e(valid_e), .load_use_stall(load_use_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: contents of the E slot as an instruction record.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] r1, r2, imm;
        logic [3:0]  ctrl;
        logic        s1;
        logic [1:0]  s2;
        logic        rw, mr, mw;
    } slot_t;

    slot_t m;

    function automatic slot_t bubble();
        slot_t s;
        s      = '0;
        s.ctrl = 4'd3;
        return s;
    endfunction

    function automatic logic [31:0] fv(input logic [4:0] src, input logic [31:0] regval);
        if (src == 5'd0) return regval;
        if (fwd_we_m && fwd_rd_m == src) return fwd_data_m;
        if (fwd_we_w && fwd_rd_w == src) return fwd_data_w;
        return regval;
    endfunction

    function automatic logic [31:0] exp_op1();
        return m.s1 ? m.pc : fv(m.rs1, m.r1);
    endfunction

    function automatic logic [31:0] exp_op2();
        if (m.s2 == 2'b00) return fv(m.rs2, m.r2);
        if (m.s2 == 2'b10) return 32'd4;
        return m.imm;
    endfunction

    function automatic logic exp_lus();
        return m.valid && m.mr && m.rd != 5'd0 && valid_d && (m.rd == rs1_d || m.rd == rs2_d);
    endfunction

    task automatic load_d(input logic v, input logic [31:0] pc, input logic [4:0] s1i,
                          input logic [4:0] s2i, input logic [4:0] rdi, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] im, input logic [3:0] ct,
                          input logic a1, input logic [1:0] a2, input logic rw, input logic mr,
                          input logic mw);
        valid_d = v; pc_d = pc; rs1_d = s1i; rs2_d = s2i; rd_d = rdi;
        reg1_d = r1; reg2_d = r2; imm_d = im; alu_ctrl_d = ct;
        alu_src1_d = a1; alu_src2_d = a2; reg_write_d = rw; mem_read_d = mr; mem_write_d = mw;
    endtask

    task automatic rand_d();
        load_d(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
               $urandom, 4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom));
    endtask

    task automatic rand_fwd();
        fwd_rd_m = 5'($urandom_range(0, 7)); fwd_we_m = 1'($urandom); fwd_data_m = $urandom;
        fwd_rd_w = 5'($urandom_range(0, 7)); fwd_we_w = 1'($urandom); fwd_data_w = $urandom;
    endtask

    task automatic fwd_off();
        fwd_rd_m = 5'd0; fwd_we_m = 1'b0; fwd_data_m = 32'd0;
        fwd_rd_w = 5'd0; fwd_we_w = 1'b0; fwd_data_w = 32'd0;
    endtask

    // One rising edge; the model takes the slot the rules say E should hold afterwards.
    task automatic step();
        slot_t n;
        if (flush_e) begin
            n = bubble();
        end else if (stall_e) begin
            n = m;
        end else begin
            n = '{valid: valid_d, pc: pc_d, rs1: rs1_d, rs2: rs2_d, rd: rd_d, r1: reg1_d,
                  r2: reg2_d, imm: imm_d, ctrl: alu_ctrl_d, s1: alu_src1_d, s2: alu_src2_d,
                  rw: reg_write_d && valid_d, mr: mem_read_d && valid_d,
                  mw: mem_write_d && valid_d};
        end
        @(posedge clk);
        #1;
        m = n;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (valid_e !== 1'b0 || alu_ctrl_e !== 4'd3) begin
            errors++;
            $display("FAIL por_state valid_e=%b alu_ctrl_e=%0d want 0/3", valid_e, alu_ctrl_e);
        end
        rst = 1'b0;
        m = bubble();
        load_d(1'b1, 32'h40, 5'd3, 5'd4, 5'd6, 32'hDEAD, 32'hBEEF, 32'h0, 4'd7, 1'b0, 2'b00,
               1'b1, 1'b1, 1'b0);
        step();
        rs1_d = 5'd6;
        #1;
        checks++;
        if (valid_e !== 1'b1 || operand1 !== 32'hDEAD || load_use_stall !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset valid_e=%b op1=%h lus=%b want 1/0000dead/1",
                     valid_e, operand1, load_use_stall);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (valid_e !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_e); end
        checks++;
        if (alu_ctrl_e !== 4'd3) begin errors++; $display("FAIL rst_ctrl got %0d want 3", alu_ctrl_e); end
        checks++;
        if (operand1 !== 32'd0 || operand2 !== 32'd0) begin
            errors++;
            $display("FAIL rst_operands got %h %h want 0 0", operand1, operand2);
        end
        checks++;
        if (load_use_stall !== 1'b0) begin errors++; $display("FAIL rst_lus got %b want 0", load_use_stall); end
        checks++;
        if (reg_write_e !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %b want 0", reg_write_e); end
        rst = 1'b0;
        m = bubble();
    endtask

    task automatic test_capture();
        fwd_off();
        load_d(1'b1, 32'h80, 5'd1, 5'd2, 5'd9, 32'h10, 32'h0, 32'hFFFFFFF0, 4'd3, 1'b0, 2'b01,
               1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (operand1 !== 32'h10 || operand2 !== 32'hFFFFFFF0 || alu_ctrl_e !== 4'd3) begin
            errors++;
            $display("FAIL capture got %h %h %0d want 00000010 fffffff0 3",
                     operand1, operand2, alu_ctrl_e);
        end
    endtask

    task automatic test_forward();
        fwd_off();
        load_d(1'b1, 32'h0, 5'd5, 5'd0, 5'd1, 32'h1234, 32'h0, 32'h0, 4'd0, 1'b0, 2'b01,
               1'b1, 1'b0, 1'b0);
        step();
        fwd_rd_m = 5'd5; fwd_we_m = 1'b1; fwd_data_m = 32'hAAAA;
        fwd_rd_w = 5'd5; fwd_we_w = 1'b1; fwd_data_w = 32'hBBBB;
        #1;
        checks++;
        if (operand1 !== 32'hAAAA) begin errors++; $display("FAIL fwd_mem_first got %h want aaaa", operand1); end
        fwd_we_m = 1'b0;
        #1;
        checks++;
        if (operand1 !== 32'hBBBB) begin errors++; $display("FAIL fwd_wb got %h want bbbb", operand1); end
        fwd_off();
        load_d(1'b1, 32'h0, 5'd0, 5'd0, 5'd1, 32'h1234, 32'h0, 32'h0, 4'd0, 1'b0, 2'b01,
               1'b1, 1'b0, 1'b0);
        step();
        fwd_rd_m = 5'd0; fwd_we_m = 1'b1; fwd_data_m = 32'hAAAA;
        fwd_rd_w = 5'd0; fwd_we_w = 1'b1; fwd_data_w = 32'hBBBB;
        #1;
        checks++;
        if (operand1 !== 32'h1234) begin errors++; $display("FAIL fwd_x0 got %h want 1234", operand1); end
        fwd_off();
    endtask

    task automatic test_stall_flush();
        fwd_off();
        load_d(1'b1, 32'h200, 5'd4, 5'd0, 5'd12, 32'h4444, 32'h0, 32'h99, 4'd5, 1'b0, 2'b01,
               1'b1, 1'b0, 1'b0);
        step();
        stall_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            step();
            checks++;
            if ({pc_e, rd_e, valid_e, alu_ctrl_e, operand1, operand2, reg_write_e} !==
                {32'h200, 5'd12, 1'b1, 4'd5, 32'h4444, 32'h99, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold edge %0d got pc=%h rd=%0d v=%b ctl=%0d op1=%h op2=%h rw=%b",
                         i, pc_e, rd_e, valid_e, alu_ctrl_e, operand1, operand2, reg_write_e);
            end
        end
        fwd_rd_m = 5'd4; fwd_we_m = 1'b1; fwd_data_m = 32'h5151;
        #1;
        checks++;
        if (operand1 !== 32'h5151) begin errors++; $display("FAIL stall_refwd got %h want 5151", operand1); end
        flush_e = 1'b1;
        step();
        checks++;
        if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || alu_ctrl_e !== 4'd3) begin
            errors++;
            $display("FAIL stall_flush got v=%b rw=%b ctl=%0d want 0/0/3", valid_e, reg_write_e, alu_ctrl_e);
        end
        stall_e = 1'b0;
        flush_e = 1'b0;
        fwd_off();
    endtask

    task automatic test_load_use();
        load_d(1'b1, 32'h300, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h8, 4'd3, 1'b0, 2'b01,
               1'b1, 1'b1, 1'b0);
        step();
        load_d(1'b1, 32'h304, 5'd3, 5'd7, 5'd8, 32'h0, 32'h0, 32'h0, 4'd3, 1'b0, 2'b00,
               1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_detect got %b want 1", load_use_stall); end
        flush_e = 1'b1;
        step();
        flush_e = 1'b0;
        checks++;
        if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_clear got %b want 0", load_use_stall); end
        load_d(1'b1, 32'h308, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h8, 4'd3, 1'b0, 2'b01,
               1'b1, 1'b1, 1'b0);
        step();
        load_d(1'b1, 32'h30C, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 4'd3, 1'b0, 2'b00,
               1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_rd0 got %b want 0", load_use_stall); end
    endtask

    task automatic test_pc_source();
        fwd_off();
        load_d(1'b1, 32'h100, 5'd1, 5'd9, 5'd2, 32'h11, 32'h55, 32'h0, 4'd3, 1'b1, 2'b10,
               1'b0, 1'b0, 1'b1);
        step();
        fwd_rd_w = 5'd9; fwd_we_w = 1'b1; fwd_data_w = 32'h77;
        #1;
        checks++;
        if (operand1 !== 32'h100 || operand2 !== 32'd4 || store_data_e !== 32'h77) begin
            errors++;
            $display("FAIL pc_source got %h %h %h want 00000100 00000004 00000077",
                     operand1, operand2, store_data_e);
        end
        fwd_off();
    endtask

    task automatic test_random();
        logic [141:0] got, exp;
        for (int i = 0; i < 400; i++) begin
            stall_e = ($urandom_range(0, 3) == 0);
            flush_e = ($urandom_range(0, 7) == 0);
            rand_d();
            rand_fwd();
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
                m = bubble();
            end
            #1;
            got = {operand1, operand2, store_data_e, pc_e, alu_ctrl_e, rd_e, reg_write_e,
                   mem_read_e, mem_write_e, valid_e, load_use_stall};
            exp = {exp_op1(), exp_op2(), fv(m.rs2, m.r2), m.pc, m.ctrl, m.rd, m.rw, m.mr,
                   m.mw, m.valid, exp_lus()};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random iter %0d got %h want %h", i, got, exp);
            end
            step();
        end
        stall_e = 1'b0;
        flush_e = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stall_e = 1'b0;
        flush_e = 1'b0;
        load_d(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 2'b00,
               1'b0, 1'b0, 1'b0);
        fwd_off();
        m = bubble();
        test_reset();
        test_capture();
        test_forward();
        test_stall_flush();
        test_load_use();
        test_pc_source();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
